nibble_serial_add_arbiter: RTL

//  Shares one 4-bit ripple adder {cout,s}=a+b+cin between two requesters.

---
 rtl/nibble_serial_add_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_add_arbiter.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_arbiter
//
// Shares one 4-bit ripple adder between two requesters. Each WIDTH-bit add is
// performed nibble-serially, LSB nibble first, with the carry chained through
// a register. Requests are arbitrated round-robin and both the request side and
// the response side use a valid/ready handshake. One operation is in flight at
// a time: IDLE -> RUN (NNIB cycles) -> RESP -> IDLE.
//
// Optional feature macro: NSA_SUB_EN
//   When defined, ports req0_sub_i / req1_sub_i are added. sub=1 latches ~B and
//   forces the initial carry to 1 (cin ignored), giving A-B mod 2^WIDTH with
//   rsp_cout_o=1 meaning "no borrow" (A>=B). When undefined: addition only.
//
// Parameters
//   WIDTH          operand/sum width, multiple of 4, >= 8
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   reqN_valid_i   requester N has an operation           (N = 0,1)
//   reqN_ready_o   requester N accepted this cycle (combinational)
//   reqN_a_i       requester N operand A
//   reqN_b_i       requester N operand B
//   reqN_cin_i     requester N carry-in
//   reqN_sub_i     requester N subtract select (NSA_SUB_EN only)
//   rsp_valid_o    result available
//   rsp_ready_i    consumer takes result
//   rsp_id_o       requester index owning the result
//   rsp_sum_o      (A+B+cin) mod 2^WIDTH
//   rsp_cout_o     carry out of the MSB nibble
// -----------------------------------------------------------------------------
module nibble_serial_add_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic             req0_cin_i,
`ifdef NSA_SUB_EN
    input  logic             req0_sub_i,
`endif
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic             req1_cin_i,
`ifdef NSA_SUB_EN
    input  logic             req1_sub_i,
`endif
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_sum_o,
    output logic             rsp_cout_o
);

    localparam int NNIB  = WIDTH / 4;
    localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               carry_q, id_q, last_q, cout_q;

    // Arbitration and operand selection
    logic               any_valid, grant_id, accept, last_nib;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               sel_cin, sel_sub;

    assign any_valid = req0_valid_i | req1_valid_i;
    // On a tie the requester that was not served last wins.
    assign grant_id  = (req0_valid_i && req1_valid_i) ? ~last_q : req1_valid_i;
    assign accept    = (state_q == ST_IDLE) && any_valid;
    assign last_nib  = (cnt_q == CNT_W'(NNIB - 1));

    assign sel_a   = grant_id ? req1_a_i   : req0_a_i;
    assign sel_b   = grant_id ? req1_b_i   : req0_b_i;
    assign sel_cin = grant_id ? req1_cin_i : req0_cin_i;
`ifdef NSA_SUB_EN
    assign sel_sub = grant_id ? req1_sub_i : req0_sub_i;
`else
    assign sel_sub = 1'b0;
`endif

    // Shared 4-bit ripple adder; operands are always the low nibble of the
    // operand shift registers, so nibble k is presented on RUN cycle k.
    logic [4:0] rc;
    logic [3:0] nib_sum;
    assign rc[0] = carry_q;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign nib_sum[gi] = a_q[gi] ^ b_q[gi] ^ rc[gi];
            assign rc[gi+1]    = (a_q[gi] & b_q[gi]) | (rc[gi] & (a_q[gi] ^ b_q[gi]));
        end
    endgenerate

    // FSM: state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_valid)   state_d = ST_RUN;
            ST_RUN:  if (last_nib)    state_d = ST_RESP;
            ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp_valid_o  = 1'b0;
        if (state_q == ST_IDLE && any_valid) begin
            req0_ready_o = ~grant_id;
            req1_ready_o = grant_id;
        end
        if (state_q == ST_RESP) begin
            rsp_valid_o = 1'b1;
        end
    end

    // Datapath: operands shift right one nibble per RUN cycle while sum
    // nibbles enter from the top, so after NNIB cycles sum_q is aligned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            // Reset as if requester 1 was served last, so requester 0 wins
            // the first tie.
            last_q  <= 1'b1;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_sub ? ~sel_b : sel_b;
            carry_q <= sel_sub ? 1'b1 : sel_cin;
            id_q    <= grant_id;
            last_q  <= grant_id;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            a_q     <= a_q >> 4;
            b_q     <= b_q >> 4;
            sum_q   <= {nib_sum, sum_q[WIDTH-1:4]};
            carry_q <= rc[4];
            cnt_q   <= cnt_q + 1'b1;
            if (last_nib) begin
                cout_q <= rc[4];
            end
        end
    end

    assign rsp_id_o   = id_q;
    assign rsp_sum_o  = sum_q;
    assign rsp_cout_o = cout_q;

endmodule
